// File: rtl/ham_pkg.sv
// +--------------------------------------------------------------------+
// | ham_pkg : shared types and helpers for the Hamming(15,11) unpacker |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package ham_pkg;

    typedef logic [15:1] code_t;
    typedef logic [10:0] data_t;

    // Element i is the code position that carries data bit i.
    localparam logic [10:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
        4'd9,  4'd7,  4'd6,  4'd5,  4'd3
    };

    // XOR of the indices of all set positions: bit k covers positions with index bit k set.
    function automatic logic [3:0] ham_syndrome(input code_t code);
        logic [3:0] s;
        s = '0;
        for (int p = 1; p <= 15; p++) begin
            if (code[p]) begin
                s = s ^ 4'(p);
            end
        end
        return s;
    endfunction

    function automatic data_t ham_extract(input code_t code);
        data_t d;
        d = '0;
        for (int i = 0; i < 11; i++) begin
            d[i] = code[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ham_fifo.sv
// +--------------------------------------------------------------------+
// | ham_fifo : generic DEPTH-entry FIFO with async active-low reset     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ham_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly PW bits, so the increment wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/ham_unpack.sv
// +--------------------------------------------------------------------+
// | ham_unpack : Hamming(15,11) data extraction + residual check, FIFO |
// | Optional macro HAM_ERRCNT_EN adds saturating err_count output.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ham_unpack
    import ham_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  code_t                    in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output data_t                    out_data,
    output logic                     out_err,
`ifdef HAM_ERRCNT_EN
    output logic [15:0]              err_count,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic        in_err;
    data_t       in_data;
    logic [11:0] wr_entry, rd_entry;

    assign in_err   = (ham_syndrome(in_code) != 4'd0);
    assign in_data  = ham_extract(in_code);
    assign wr_entry = {in_err, in_data};

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    ham_fifo #(
        .WIDTH (12),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Storage is unreset, so mask the read port whenever nothing is buffered.
    assign out_data = out_valid ? rd_entry[10:0] : '0;
    assign out_err  = out_valid ? rd_entry[11]   : 1'b0;

`ifdef HAM_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (push && in_err && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ham_unpack.sv
// +--------------------------------------------------------------------+
// | tb_ham_unpack : directed table-driven bench for ham_unpack         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ham_unpack;
    import ham_pkg::*;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    code_t       in_code;
    logic        out_valid;
    logic        out_ready;
    data_t       out_data;
    logic        out_err;
    logic [2:0]  count;
`ifdef HAM_ERRCNT_EN
    logic [15:0] err_count;
`endif

    ham_unpack #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
`ifdef HAM_ERRCNT_EN
        .err_count (err_count),
`endif
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [14:0] code;
        logic [10:0] data;
        logic        err;
    } vec_t;

    vec_t tbl [10];
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_code   = '0;
        tick();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] exp_q [$];
        logic        err_q [$];
        int          k;

        n_pass  = 0;
        n_total = 0;

        //           code      data    err
        tbl[0] = '{15'h7FFF, 11'h7FF, 1'b0};
        tbl[1] = '{15'h0001, 11'h000, 1'b1};
        tbl[2] = '{15'h0004, 11'h001, 1'b1};
        tbl[3] = '{15'h0007, 11'h001, 1'b0};
        tbl[4] = '{15'h4000, 11'h400, 1'b1};
        tbl[5] = '{15'h408B, 11'h400, 1'b0};
        tbl[6] = '{15'h0080, 11'h000, 1'b1};
        tbl[7] = '{15'h0030, 11'h006, 1'b1};
        tbl[8] = '{15'h0033, 11'h006, 1'b0};
        tbl[9] = '{15'h7FFE, 11'h7FF, 1'b1};

        // Reset values while reset_n is low
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_code   = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        tick();
        @(negedge clock);
        reset_n = 1'b1;

        // Single-word latency + extraction/syndrome per table entry
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_code  = tbl[i].code;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_data", i),  32'(out_data),  32'(tbl[i].data));
            chk($sformatf("v%0d_err", i),   32'(out_err),   32'(tbl[i].err));
            chk($sformatf("v%0d_count", i), 32'(count),     32'd1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_empty", i), 32'(out_valid), 32'd0);
        end

`ifdef HAM_ERRCNT_EN
        do_reset();
        chk("ec_reset", 32'(err_count), 32'd0);
        in_valid = 1'b1;
        in_code  = 15'h0001;
        tick();
        in_valid = 1'b0;
        chk("ec_one", 32'(err_count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        force dut.err_count_q = 16'hFFFE;
        #1;
        release dut.err_count_q;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_code   = 15'h0004;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("ec_saturate", 32'(err_count), 32'hFFFF);
`endif

        // Fill to full with out_ready low; the fifth word must be refused
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = tbl[2].code; tick();
        in_code   = tbl[7].code; tick();
        in_code   = tbl[4].code; tick();
        chk("fill_ready3", 32'(in_ready), 32'd1);
        in_code   = tbl[0].code; tick();
        chk("full_count",  32'(count),    32'd4);
        chk("full_ready",  32'(in_ready), 32'd0);
        in_code   = tbl[6].code; tick();
        chk("full_hold",   32'(count),    32'd4);
        chk("full_head",   32'(out_data), 32'(tbl[2].data));
        // Pop while full with in_valid still high: no word admitted this cycle
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_pop_count", 32'(count),    32'd3);
        chk("drain1_data",    32'(out_data), 32'(tbl[7].data));
        tick();
        chk("drain2_data",    32'(out_data), 32'(tbl[4].data));
        chk("drain2_err",     32'(out_err),  32'(tbl[4].err));
        tick();
        chk("drain3_data",    32'(out_data), 32'(tbl[0].data));
        chk("drain3_err",     32'(out_err),  32'(tbl[0].err));
        tick();
        out_ready = 1'b0;
        chk("drain_empty",    32'(out_valid), 32'd0);
        chk("drain_count",    32'(count),     32'd0);

        // Steady push+pop at count 2: order preserved, pointers wrap
        exp_q.delete();
        err_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_code = tbl[i].code;
            exp_q.push_back(tbl[i].data);
            err_q.push_back(tbl[i].err);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            k = (c + 2) % 10;
            in_code = tbl[k].code;
            chk($sformatf("stream%0d_data", c), 32'(out_data), 32'(exp_q[0]));
            chk($sformatf("stream%0d_err", c),  32'(out_err),  32'(err_q[0]));
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            exp_q.push_back(tbl[k].data);
            err_q.push_back(tbl[k].err);
            tick();
            chk($sformatf("stream%0d_count", c), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        chk("stream_tail0", 32'(out_data), 32'(exp_q[0]));
        tick();
        chk("stream_tail1", 32'(out_data), 32'(exp_q[1]));
        tick();
        out_ready = 1'b0;
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream with three words buffered
        in_valid = 1'b1;
        for (int i = 3; i < 6; i++) begin
            in_code = tbl[i].code;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        chk("arst_data",  32'(out_data),  32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_code  = tbl[9].code;
        tick();
        in_valid = 1'b0;
        chk("post_rst_count", 32'(count),    32'd1);
        chk("post_rst_data",  32'(out_data), 32'(tbl[9].data));
        chk("post_rst_err",   32'(out_err),  32'(tbl[9].err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
